// File: rtl/calc_engine.sv
// calc_engine: keypad-driven fixed-point calculator with sequential
// add/sub/mul and a restoring divider; values are integers scaled by 10^FRAC_DIGITS.
module calc_engine #(
    parameter int NUM_DIGITS  = 4,
    parameter int FRAC_DIGITS = 3,
    parameter int W           = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                key_ready,
    output logic signed [W-1:0] disp_value,
    output logic                disp_frac,
    output logic                disp_valid,
    output logic                error,
    output logic                busy
);
    localparam int XW = 2 * W;
    localparam int CW = $clog2(XW);

    function automatic logic signed [XW-1:0] pow10(input int n);
        pow10 = 1;
        for (int i = 0; i < n; i++) pow10 = pow10 * 10;
    endfunction

    localparam logic signed [XW-1:0] SCALE_X = pow10(FRAC_DIGITS);
    localparam logic signed [XW-1:0] MAX_V   = (pow10(NUM_DIGITS) - 1) * SCALE_X;
    localparam logic signed [XW-1:0] MIN_V   = -((pow10(NUM_DIGITS - 1) - 1) * SCALE_X);
    localparam logic signed [W-1:0]  SCALE   = SCALE_X[W-1:0];
    localparam logic signed [W-1:0]  TEN     = W'(10);
    localparam logic [7:0]           DLIM    = 8'(NUM_DIGITS);
    localparam logic [7:0]           FLIM    = 8'(FRAC_DIGITS);

    typedef enum logic [2:0] {CLEAR, IDLE, ENTRY, OPER, MULDIV, DIVITER, RESULT} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t               state_q;
    op_t                  pend_q, op_q;
    logic signed [W-1:0]  arg_q, acc_q, fs_q, disp_q;
    logic signed [XW-1:0] res_q;
    logic [W-1:0]         dvs_q, rem_q;
    logic [CW-1:0]        cnt_q;
    logic [7:0]           dig_q, frac_q;
    logic                 neg_q, dp_q, qneg_q, dv_q, err_q, busy_q;

    logic                 accept, is_dig, is_sign, dig_full, err_d, ge;
    logic signed [W-1:0]  kd, add_v, arg_d;
    logic signed [XW-1:0] acc_x, arg_x, acc_abs, mul_d;
    logic [W-1:0]         arg_abs;
    logic [W:0]           rem_sh;
    logic [XW-1:0]        q_d;

    assign key_ready  = state_q == IDLE;
    assign disp_value = disp_q;
    assign disp_frac  = dp_q;
    assign disp_valid = dv_q;
    assign error      = err_q;
    assign busy       = busy_q;

    always_comb begin
        accept   = key_valid && state_q == IDLE;
        is_dig   = key_code <= 4'd9;
        is_sign  = key_code == 4'hB && dig_q == 8'd0 && !neg_q;
        dig_full = dig_q >= (neg_q ? DLIM - 8'd1 : DLIM) || (dp_q && frac_q >= FLIM);
        kd       = W'(key_code);
        add_v    = kd * (dp_q ? fs_q : SCALE);
        arg_d    = (dp_q ? arg_q : arg_q * TEN) + (neg_q ? -add_v : add_v);
        acc_x    = {{W{acc_q[W-1]}}, acc_q};
        arg_x    = {{W{arg_q[W-1]}}, arg_q};
        acc_abs  = acc_q[W-1] ? -acc_x : acc_x;
        arg_abs  = arg_q[W-1] ? -arg_q : arg_q;
        mul_d    = acc_x * arg_x / SCALE_X;
        rem_sh   = {rem_q, res_q[XW-1]};
        ge       = rem_sh >= {1'b0, dvs_q};
        q_d      = {res_q[XW-2:0], ge};
        // all error sources funnel into one path that zeroes the display and clears
        err_d    = (accept && ((is_dig && dig_full) || (key_code == 4'hF && dp_q)))
                || (state_q == MULDIV && op_q == OP_DIV && arg_q == '0)
                || (state_q == RESULT && (res_q > MAX_V || res_q < MIN_V));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            pend_q  <= OP_ADD;
            op_q    <= OP_ADD;
            arg_q   <= '0;
            acc_q   <= '0;
            fs_q    <= '0;
            disp_q  <= '0;
            res_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            frac_q  <= '0;
            neg_q   <= 1'b0;
            dp_q    <= 1'b0;
            qneg_q  <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (err_d) begin
                err_q   <= 1'b1;
                disp_q  <= '0;
                dv_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= CLEAR;
            end else begin
                if (accept) err_q <= 1'b0;
                case (state_q)
                    CLEAR: begin
                        arg_q   <= '0;
                        acc_q   <= '0;
                        res_q   <= '0;
                        fs_q    <= SCALE / TEN;
                        dig_q   <= '0;
                        frac_q  <= '0;
                        neg_q   <= 1'b0;
                        dp_q    <= 1'b0;
                        pend_q  <= OP_ADD;
                        disp_q  <= '0;
                        state_q <= IDLE;
                    end
                    IDLE: if (accept) begin
                        if (is_dig) begin
                            arg_q <= arg_d;
                            dig_q <= dig_q + 8'd1;
                            if (dp_q) begin
                                frac_q <= frac_q + 8'd1;
                                fs_q   <= fs_q / TEN;
                            end
                            state_q <= ENTRY;
                        end else if (key_code == 4'hF) begin
                            dp_q    <= 1'b1;
                            state_q <= ENTRY;
                        end else if (key_code == 4'hE) begin
                            state_q <= CLEAR;
                        end else if (is_sign) begin
                            neg_q   <= 1'b1;
                            state_q <= ENTRY;
                        end else begin
                            // A,B,C,D map onto add,sub,mul,div; the pending op runs now
                            op_q    <= pend_q;
                            pend_q  <= op_t'({~key_code[1], key_code[0]});
                            busy_q  <= 1'b1;
                            state_q <= pend_q[1] ? MULDIV : OPER;
                        end
                    end
                    ENTRY: begin
                        disp_q  <= arg_q;
                        dv_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                    OPER: begin
                        res_q   <= op_q == OP_SUB ? acc_x - arg_x : acc_x + arg_x;
                        state_q <= RESULT;
                    end
                    MULDIV: if (op_q == OP_MUL) begin
                        res_q   <= mul_d;
                        state_q <= RESULT;
                    end else begin
                        res_q   <= acc_abs * SCALE_X;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dvs_q   <= arg_abs;
                        qneg_q  <= acc_q[W-1] ^ arg_q[W-1];
                        state_q <= DIVITER;
                    end
                    DIVITER: begin
                        rem_q <= ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XW - 1)) begin
                            res_q   <= qneg_q ? -q_d : q_d;
                            state_q <= RESULT;
                        end else begin
                            res_q <= q_d;
                        end
                    end
                    RESULT: begin
                        acc_q   <= res_q[W-1:0];
                        disp_q  <= res_q[W-1:0];
                        dv_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        arg_q   <= '0;
                        dig_q   <= '0;
                        frac_q  <= '0;
                        neg_q   <= 1'b0;
                        dp_q    <= 1'b0;
                        fs_q    <= SCALE / TEN;
                        state_q <= IDLE;
                    end
                    default: state_q <= CLEAR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed and random key sequences checked against an
// arithmetic model of the calculator working on plain 64-bit integers.
module tb_calc_engine;
    localparam int W  = 32;
    localparam int ND = 4;
    localparam int FD = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                key_valid = 1'b0;
    logic [3:0]          key_code = 4'd0;
    logic                key_ready, disp_frac, disp_valid, error, busy;
    logic signed [W-1:0] disp_value;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_acc, m_arg;
    int     m_dig, m_frac, m_pend;
    bit     m_neg, m_dp;

    always #5 clk = ~clk;

    calc_engine #(.NUM_DIGITS(ND), .FRAC_DIGITS(FD), .W(W)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .disp_value(disp_value), .disp_frac(disp_frac),
        .disp_valid(disp_valid), .error(error), .busy(busy)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint p10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    task automatic m_clear();
        m_acc = 0; m_arg = 0; m_dig = 0; m_frac = 0; m_pend = 0; m_neg = 0; m_dp = 0;
    endtask

    // kind: 0 clear key, 1 entry echo, 2 arithmetic result, 3 error
    task automatic model_key(input logic [3:0] k, output int kind, output longint val, output int lat);
        longint s, r;
        int     nop;
        s = m_neg ? -1 : 1;
        kind = 3; val = 0; lat = 0; r = 0;
        if (k <= 9) begin
            if (!(m_dig >= (m_neg ? ND - 1 : ND) || (m_dp && m_frac >= FD))) begin
                m_dig++;
                if (m_dp) begin
                    m_frac++;
                    m_arg += s * longint'(k) * p10(FD - m_frac);
                end else m_arg = m_arg * 10 + s * longint'(k) * p10(FD);
                kind = 1;
            end
        end else if (k == 4'hF) begin
            if (!m_dp) begin m_dp = 1; kind = 1; end
        end else if (k == 4'hE) begin
            kind = 0;
        end else if (k == 4'hB && m_dig == 0 && !m_neg) begin
            m_neg = 1; kind = 1;
        end else begin
            nop = (k == 4'hA) ? 0 : (k == 4'hB) ? 1 : (k == 4'hC) ? 2 : 3;
            lat = (m_pend == 3) ? 2 * W + 2 : 2;
            if (!(m_pend == 3 && m_arg == 0)) begin
                case (m_pend)
                    0: r = m_acc + m_arg;
                    1: r = m_acc - m_arg;
                    2: r = (m_acc * m_arg) / p10(FD);
                    default: r = (m_acc * p10(FD)) / m_arg;
                endcase
                if (!(r > (p10(ND) - 1) * p10(FD) || r < -(p10(ND - 1) - 1) * p10(FD))) begin
                    kind = 2; val = r; m_acc = r; m_arg = 0; m_dig = 0; m_frac = 0;
                    m_neg = 0; m_dp = 0; m_pend = nop;
                end
            end
        end
        if (kind == 1) val = m_arg;
        if (kind == 0 || kind == 3) m_clear();
    endtask

    // entered at a falling edge, returns at a falling edge
    task automatic send_key(input logic [3:0] k);
        int     kind, lat, c, w;
        longint val;
        w = 0;
        while (!key_ready && w < 200) begin @(negedge clk); w++; end
        chk("key_ready", key_ready, 1);
        key_valid = 1'b1;
        key_code  = k;
        model_key(k, kind, val, lat);
        @(posedge clk); #1;
        key_valid = 1'b0;
        if (kind == 0) begin
            w = 0;
            while (!key_ready && w < 10) begin @(negedge clk); w++; end
            chk("clear_value", disp_value, 0);
            chk("clear_error", error, 0);
        end else begin
            c = 0;
            while (!disp_valid && c < 200) begin
                @(posedge clk); #1; c++;
                if (c == 1 && kind == 2) chk("busy", busy, 1);
            end
            chk("disp_valid", disp_valid, 1);
            chk("value", disp_value, val);
            chk("error", error, kind == 3);
            if (kind == 2) begin
                chk("latency", c, lat);
                chk("busy_end", busy, 0);
            end
            if (kind != 3) chk("frac", disp_frac, kind == 1 ? m_dp : 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic send_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) send_key(ks[i]);
    endtask

    function automatic logic [3:0] rand_key();
        int r = $urandom_range(0, 99);
        if (r < 55) return 4'($urandom_range(0, 9));
        if (r < 62) return 4'hF;
        if (r < 64) return 4'hE;
        if (r < 74) return 4'hB;
        if (r < 82) return 4'hA;
        if (r < 91) return 4'hC;
        return 4'hD;
    endfunction

    initial begin
        int     kind, lat, c, seen;
        longint val;
        repeat (3) @(negedge clk);
        chk("rst_value", disp_value, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frac", disp_frac, 0);
        chk("rst_ready", key_ready, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", key_ready, 1);
        m_clear();

        send_seq('{4'd1, 4'd2, 4'hA});
        chk("add_first", disp_value, 12000);
        send_seq('{4'd3, 4'hA});
        chk("add_second", disp_value, 15000);
        chk("add_err", error, 0);

        send_seq('{4'hE, 4'hB, 4'd5, 4'hB});
        chk("neg_sub", disp_value, -5000);
        send_seq('{4'd2, 4'hA});
        chk("neg_final", disp_value, -7000);

        send_seq('{4'hE, 4'd2, 4'hF, 4'd5});
        chk("dp_frac", disp_frac, 1);
        send_seq('{4'hC, 4'd4, 4'hA});
        chk("mul_final", disp_value, 10000);

        send_seq('{4'hE, 4'd1, 4'd0, 4'hD, 4'd3, 4'hA});
        chk("div_final", disp_value, 3333);
        send_seq('{4'd7, 4'hD, 4'd0, 4'hA});
        chk("div0_err", error, 1);
        chk("div0_value", disp_value, 0);

        send_seq('{4'hE, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
        chk("digit_limit_err", error, 1);
        send_key(4'd6);
        chk("err_cleared", error, 0);

        send_seq('{4'hE, 4'd9, 4'd9, 4'd9, 4'd9, 4'hC, 4'd2, 4'hA});
        chk("ovf_err", error, 1);
        chk("ovf_value", disp_value, 0);

        // keys offered while the divider is busy must be dropped
        send_seq('{4'hE, 4'd1, 4'd0, 4'hD, 4'd3});
        key_valid = 1'b1;
        key_code  = 4'hA;
        model_key(4'hA, kind, val, lat);
        @(posedge clk); #1;
        key_code = 4'd7;
        c = 0;
        while (!disp_valid && c < 200) begin @(posedge clk); #1; c++; end
        key_valid = 1'b0;
        chk("ign_valid", disp_valid, 1);
        chk("ign_value", disp_value, val);
        chk("ign_latency", c, lat);
        @(negedge clk);
        send_seq('{4'd2, 4'hA});
        chk("ign_after", disp_value, 5333);

        // reset during DIVITER
        send_seq('{4'hE, 4'd1, 4'd0, 4'hD, 4'd3});
        key_valid = 1'b1;
        key_code  = 4'hA;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_value", disp_value, 0);
        chk("mid_rst_valid", disp_valid, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_frac", disp_frac, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (2) begin @(negedge clk); if (disp_valid) seen = 1; end
        chk("mid_rst_ready", key_ready, 1);
        repeat (100) begin @(negedge clk); if (disp_valid) seen = 1; end
        chk("mid_rst_no_valid", seen, 0);
        m_clear();

        repeat (150) send_key(rand_key());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
